defuzz9_seq: RTL

DEFUZZ9_SEQ -- requirements
Module: defuzz9_seq

---
 rtl/defuzz9_seq_if.sv | 9 +
 rtl/defuzz9_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/defuzz9_seq_if.sv
// defuzz9_seq_if: request, rule weights and crisp result bundle for defuzz9_seq
interface defuzz9_seq_if;
    logic start;
    logic [15:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic busy, valid, zero_w;
    logic signed [15:0] y;
    modport master (output start, w00, w01, w02, w10, w11, w12, w20, w21, w22, input busy, valid, y, zero_w);
    modport slave (input start, w00, w01, w02, w10, w11, w12, w20, w21, w22, output busy, valid, y, zero_w);
endinterface

// File: rtl/defuzz9_seq.sv
// defuzz9_seq: sequential singleton defuzzifier, y = sum(w*C)/sum(w) over a 3x3 rule grid
module defuzz9_seq #(
    parameter logic [143:0] COEF = {16'h8000, 16'hA000, 16'hC000, 16'hE000, 16'h0000,
                                    16'h2000, 16'h4000, 16'h6000, 16'h7FFF},
    parameter logic signed [15:0] DEFAULT_Y = 16'sd0
) (
    input logic clk,
    input logic rst_n,
    defuzz9_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;
    state_t state;
    logic [15:0] ws [9];
    logic [3:0] cnt, idx;
    logic signed [36:0] num;
    logic [19:0] den;
    logic [35:0] rem, dv;
    logic [15:0] q, qn;
    logic neg, ge;
    logic signed [15:0] c_sel;
    logic signed [32:0] prod;
    always_comb begin
        idx = (cnt < 4'd9) ? cnt : 4'd0;
        c_sel = $signed(COEF[16*idx +: 16]);
        prod = $signed({1'b0, ws[idx]}) * c_sel;
        ge = rem >= dv;
        qn = {q[14:0], ge};
    end
    // ACC spends a tenth cycle (cnt == 9) deciding on den once the last rule has landed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            for (int k = 0; k < 9; k++) ws[k] <= '0;
            cnt <= '0;
            num <= '0;
            den <= '0;
            rem <= '0;
            dv <= '0;
            q <= '0;
            neg <= 1'b0;
            bus.busy <= 1'b0;
            bus.valid <= 1'b0;
            bus.y <= '0;
            bus.zero_w <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    ws[0] <= bus.w00;
                    ws[1] <= bus.w01;
                    ws[2] <= bus.w02;
                    ws[3] <= bus.w10;
                    ws[4] <= bus.w11;
                    ws[5] <= bus.w12;
                    ws[6] <= bus.w20;
                    ws[7] <= bus.w21;
                    ws[8] <= bus.w22;
                    num <= '0;
                    den <= '0;
                    cnt <= '0;
                    q <= '0;
                    bus.busy <= 1'b1;
                    state <= ACC;
                end
                ACC: if (cnt < 4'd9) begin
                    num <= num + 37'(prod);
                    den <= den + 20'(ws[idx]);
                    cnt <= cnt + 4'd1;
                end else if (den != '0) begin
                    neg <= num[36];
                    rem <= num[36] ? 36'(-num) : 36'(num);
                    dv <= 36'({den, 15'd0});
                    cnt <= '0;
                    state <= DIV;
                end else begin
                    bus.y <= DEFAULT_Y;
                    bus.zero_w <= 1'b1;
                    bus.valid <= 1'b1;
                    state <= DONE;
                end
                DIV: begin
                    if (ge) rem <= rem - dv;
                    dv <= dv >> 1;
                    q <= qn;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        bus.y <= neg ? 16'(-qn) : qn;
                        bus.zero_w <= 1'b0;
                        bus.valid <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    bus.valid <= 1'b0;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
